// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: applies one single-position shift per clock to a latched
// operand until the requested amount is consumed, with a start/busy/done handshake.
module seq_shift_unit #(
  parameter int N   = 8,
  parameter int SHW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [SHW-1:0] amt,
  input  logic [1:0]     op,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   sr;
  logic [SHW-1:0] cnt;
  logic [1:0]     opr;

  // One position of the selected shift; amounts >= N saturate or wrap naturally.
  function automatic logic [N-1:0] shift_step(input logic [N-1:0] v, input logic [1:0] o);
    logic [N-1:0] r;
    case (o)
      2'b00:   r = {1'b0, v[N-1:1]};
      2'b01:   r = {v[N-1], v[N-1:1]};
      2'b10:   r = {v[N-2:0], 1'b0};
      default: r = {v[0], v[N-1:1]};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      opr    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sr    <= a;
            cnt   <= amt;
            opr   <= op;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            sr  <= shift_step(sr, opr);
            cnt <= cnt - SHW'(1);
          end else begin
            result <= sr;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: directed vector table, handshake
// corner sequences and randomized operations against an arithmetic model.
module tb_seq_shift_unit;

  localparam int N   = 8;
  localparam int SHW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N-1:0]   a;
  logic [SHW-1:0] amt;
  logic [1:0]     op;
  logic           busy;
  logic           done;
  logic [N-1:0]   result;

  int n_chk  = 0;
  int n_fail = 0;

  seq_shift_unit #(.N(N), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .amt(amt), .op(op),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   a;
    logic [SHW-1:0] amt;
    logic [1:0]     op;
    logic [N-1:0]   exp;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: whole-amount shift computed directly from the operation rules.
  function automatic logic [N-1:0] model(input logic [N-1:0] v, input int sh, input logic [1:0] o);
    logic [N-1:0] lo, hi;
    int r;
    case (o)
      2'b00: return (sh >= N) ? '0 : v >> sh;
      2'b01: return (sh >= N) ? {N{v[N-1]}} : N'($signed(v) >>> sh);
      2'b10: return (sh >= N) ? '0 : v << sh;
      default: begin
        r = sh % N;
        if (r == 0) return v;
        lo = v >> r;
        hi = v << (N - r);
        return lo | hi;
      end
    endcase
  endfunction

  task automatic issue(input logic [N-1:0] va, input logic [SHW-1:0] vamt, input logic [1:0] vop);
    @(negedge clk);
    a = va; amt = vamt; op = vop; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called #1 after the accepting edge; counts edges until done and busy cycles.
  task automatic wait_done(output logic [N-1:0] res, output int lat, output int bcnt);
    bcnt = busy ? 1 : 0;
    lat  = 0;
    res  = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 lat++;
      if (done) begin
        res = result;
        return;
      end
      if (busy) bcnt++;
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic run_check(input string name, input logic [N-1:0] va, input logic [SHW-1:0] vamt,
                           input logic [1:0] vop, input logic [N-1:0] exp);
    logic [N-1:0] res;
    int lat, bcnt;
    issue(va, vamt, vop);
    wait_done(res, lat, bcnt);
    check({name, "_result"}, int'(res), int'(exp));
    check({name, "_latency"}, lat, int'(vamt) + 1);
    check({name, "_busy"}, bcnt, int'(vamt) + 1);
  endtask

  initial begin
    vec_t vecs[$];
    logic [N-1:0] res, ra;
    logic [SHW-1:0] ramt;
    logic [1:0] rop;
    int lat, bcnt, seen;

    vecs.push_back('{8'hB4, 3'd3, 2'b00, 8'h16});
    vecs.push_back('{8'hB4, 3'd3, 2'b01, 8'hF6});
    vecs.push_back('{8'hB4, 3'd3, 2'b10, 8'hA0});
    vecs.push_back('{8'hB4, 3'd3, 2'b11, 8'h96});
    vecs.push_back('{8'h5A, 3'd0, 2'b00, 8'h5A});
    vecs.push_back('{8'h5A, 3'd0, 2'b01, 8'h5A});
    vecs.push_back('{8'h5A, 3'd0, 2'b10, 8'h5A});
    vecs.push_back('{8'h5A, 3'd0, 2'b11, 8'h5A});
    vecs.push_back('{8'hFF, 3'd7, 2'b00, 8'h01});
    vecs.push_back('{8'hFF, 3'd7, 2'b10, 8'h80});
    vecs.push_back('{8'hFF, 3'd7, 2'b01, 8'hFF});
    vecs.push_back('{8'h81, 3'd7, 2'b11, 8'h03});

    rst = 1'b1; start = 1'b0; a = '0; amt = '0; op = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_result", int'(result), 0);
    @(negedge clk) rst = 1'b0;

    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].amt, vecs[i].op, vecs[i].exp);

    // Start held high with changing operands throughout the operation.
    issue(8'hB4, 3'd3, 2'b00);
    lat = 0; seen = 0; res = '0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy) begin
        start = 1'b1; a = N'($urandom); amt = SHW'($urandom); op = 2'($urandom);
      end
      @(posedge clk);
      #1 lat++;
      if (done) begin seen = 1; res = result; end
    end
    @(negedge clk) start = 1'b0;
    check("ignored_start_seen", seen, 1);
    check("ignored_start_result", int'(res), 8'h16);
    check("ignored_start_latency", lat, 4);
    @(posedge clk);
    #1;
    check("ignored_start_idle_busy", int'(busy), 0);
    check("ignored_start_idle_done", int'(done), 0);

    // Back-to-back: second start lands in the DONE cycle.
    issue(8'hC3, 3'd2, 2'b11);
    wait_done(res, lat, bcnt);
    check("b2b_first_result", int'(res), 8'hF0);
    run_check("b2b_second", 8'h0F, 3'd5, 2'b10, 8'hE0);

    // Reset mid-operation aborts with no done pulse.
    issue(8'hA5, 3'd6, 2'b01);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_result", int'(result), 0);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1 if (done || busy) seen = 1;
    end
    check("midrst_no_done", seen, 0);
    run_check("post_rst", 8'h96, 3'd4, 2'b01, 8'hF9);

    for (int i = 0; i < 40; i++) begin
      ra = N'($urandom); ramt = SHW'($urandom); rop = 2'($urandom);
      run_check($sformatf("rand%0d", i), ra, ramt, rop, model(ra, int'(ramt), rop));
      if ($urandom_range(1, 0) == 1) @(posedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
Multi-cycle shifter that sits directly upstream of the datapath's single-position shift stages. It repeatedly applies a one-bit shift to a latched operand, one position per clock, until the requested amount is consumed. Supported operations are logical right, arithmetic right, logical left and rotate right. Uses a start/busy/done handshake so the ALU controller can issue shifts of arbitrary amount with a bounded, amount-dependent latency.

Parameters:
N, 8, operand/result width in bits (N >= 2)
SHW, 3, shift-amount width in bits; amounts 0..2^SHW-1 are legal, including amounts >= N

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
a  input  N  operand, latched on accepted start
amt  input  SHW  shift amount, latched on accepted start
op  input  2  operation, latched on accepted start: 00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right
busy  output  1  high while an operation is in progress (SHIFT state)
done  output  1  one-cycle pulse: result valid
result  output  N  final shifted value; held until next accepted start completes

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, result=0, internal operand/count/op registers=0.
- Reset has priority over all other inputs.
- Reset mid-operation aborts the operation; no done pulse is produced and result reads 0.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1 for exactly one cycle.
- Accept: start=1 at a rising edge while state is IDLE or DONE.
  - Latch a into the shift register, amt into the counter and op into the op register.
  - Go to SHIFT.
  - Back-to-back issue from DONE is legal.
- SHIFT, counter != 0: shift the register one position per op and decrement the counter.
  - op 00: insert 0 at the MSB.
  - op 01: replicate the MSB.
  - op 10: insert 0 at the LSB.
  - op 11: the LSB moves to the MSB.
- SHIFT, counter == 0: copy the shift register to result and go to DONE.
- DONE: return to IDLE on the next edge unless a new start is accepted.
- Latency: with the start accepted at edge k, done is high in the cycle following edge k+amt+1 (amt=0 gives done one cycle after acceptance).
- busy is high for exactly amt+1 cycles per operation.
- start while busy=1 is ignored; latched operands are unaffected.
- Changes on a/amt/op after acceptance have no effect.
- Amounts >= N iterate the full count, so latency is always amt+1.
  - Logical shifts saturate to 0.
  - Arithmetic right saturates to all-MSB.
  - Rotate wraps modulo N.
- result changes only on the edge that enters DONE.

Test Plan:
- N=8, SHW=3. Issue a=8'hB4, amt=3, op=00 -> done 4 cycles after the accepting edge, result=8'h16, busy high for 4 cycles.
- a=8'hB4, amt=3: op=01 -> result=8'hF6; op=10 -> result=8'hA0; op=11 -> result=8'h96; each with identical latency.
- amt=0, a=8'h5A, any op -> result=8'h5A, done one cycle after acceptance, busy high for 1 cycle.
- a=8'hFF, amt=7: op=00 -> 8'h01; op=10 -> 8'h80; op=01 -> 8'hFF.
- Back-to-back and ignored start:
  - Assert start with new operands every cycle while busy -> only the first operation executes and its result is unchanged.
  - Start accepted in the DONE cycle -> the next operation runs correctly.
- Reset: assert rst during SHIFT of an amt=6 operation -> next cycle busy=0, done=0, result=0, and no done pulse afterwards.
  - After rst deasserts, a fresh start completes normally.
